// File: rtl/usbfs_pkg.sv
// Shared USB full-speed definitions: PID codes, PID classes, CRC constants and FSM states.
package usbfs_pkg;

  typedef enum logic [3:0] {
    PID_OUT   = 4'h1,
    PID_IN    = 4'h9,
    PID_SOF   = 4'h5,
    PID_SETUP = 4'hD,
    PID_DATA0 = 4'h3,
    PID_DATA1 = 4'hB,
    PID_ACK   = 4'h2,
    PID_NAK   = 4'hA,
    PID_STALL = 4'hE
  } pid_t;

  typedef enum logic [1:0] {
    CLS_SPECIAL   = 2'b00,
    CLS_TOKEN     = 2'b01,
    CLS_HANDSHAKE = 2'b10,
    CLS_DATA      = 2'b11
  } pid_class_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RX_PID    = 3'd1,
    RX_DATA   = 3'd2,
    RESP_WAIT = 3'd3,
    TX_PID    = 3'd4,
    TX_DATA   = 3'd5,
    TX_CRC    = 3'd6,
    TX_END    = 3'd7
  } state_t;

  // Reflected (LSB-first) polynomials, presets and good-packet residuals
  localparam logic [4:0]  CRC5_POLY      = 5'h14;
  localparam logic [4:0]  CRC5_PRESET    = 5'h1F;
  localparam logic [4:0]  CRC5_RESIDUAL  = 5'b00110;
  localparam logic [15:0] CRC16_POLY     = 16'hA001;
  localparam logic [15:0] CRC16_PRESET   = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'hB001;

  function automatic logic [15:0] crc_poly(input int w);
    if (w == 32'sd5) return {11'd0, CRC5_POLY};
    else             return CRC16_POLY;
  endfunction

  function automatic logic [15:0] crc_preset(input int w);
    if (w == 32'sd5) return {11'd0, CRC5_PRESET};
    else             return CRC16_PRESET;
  endfunction

  function automatic logic crc5_residual_ok(input logic [4:0] c);
    return (c == CRC5_RESIDUAL);
  endfunction

  function automatic logic crc16_residual_ok(input logic [15:0] c);
    return (c == CRC16_RESIDUAL);
  endfunction

endpackage

// File: rtl/usbfs_crc.sv
// Serial 1-bit reflected CRC engine; W selects CRC5 (W=5) or CRC16 (W=16).
module usbfs_crc
  import usbfs_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         init,
  input  logic         en,
  input  logic         din,
  output logic [W-1:0] crc
);

  localparam logic [W-1:0] POLY_C   = W'(crc_poly(W));
  localparam logic [W-1:0] PRESET_C = W'(crc_preset(W));

  logic [W-1:0] crc_s;

  // One LSB-first shift step with feedback into the reflected polynomial
  always_comb begin
    crc_s = {1'b0, crc[W-1:1]};
    if (crc[0] ^ din) begin
      crc_s = crc_s ^ POLY_C;
    end else begin
      crc_s = {1'b0, crc[W-1:1]};
    end
  end

  // CRC register: preset on init, advance on each enabled bit
  always_ff @(posedge clk) begin
    if (rst) begin
      crc <= PRESET_C;
    end else if (init) begin
      crc <= PRESET_C;
    end else if (en) begin
      crc <= crc_s;
    end
  end

endmodule

// File: rtl/usbfs_packet_ctrl.sv
// USB full-speed packet sequencer between the bit-level transceiver and the transaction layer.
// Define USBFS_CRC_CHECK_EN to let RX CRC5/CRC16 residuals gate rp_okay.
module usbfs_packet_ctrl
  import usbfs_pkg::*;
#(
  parameter int RX_MAXLEN = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_sta,
  input  logic       rx_ena,
  input  logic       rx_bit,
  input  logic       rx_fin,
  output logic       tx_sta,
  input  logic       tx_req,
  output logic       tx_bit,
  output logic       tx_fin,
  output logic [3:0] rp_pid,
  output logic       rp_byte_en,
  output logic [7:0] rp_byte,
  output logic       rp_fin,
  output logic       rp_okay,
  input  logic       tp_sta,
  input  logic [3:0] tp_pid,
  output logic       tp_req,
  input  logic [7:0] tp_byte,
  input  logic       tp_end
);

  localparam int BCW = $clog2(RX_MAXLEN + 4) + 1;
  localparam logic [BCW-1:0] TWO_C     = BCW'(32'd2);
  localparam logic [BCW-1:0] MAX_LEN_C = BCW'(RX_MAXLEN + 32'd2);
  localparam logic [BCW-1:0] SAT_C     = {BCW{1'b1}};

  state_t         state_r, state_s;
  logic [7:0]     rx_sh_r, hold0_r, hold1_r;
  logic [2:0]     rx_bit_cnt_r;
  logic [BCW-1:0] rx_byte_cnt_r;
  logic           pid_ok_r;
  logic [3:0]     tx_pid_r, tx_cnt_r;
  logic [7:0]     tx_buf_r;
  logic           tp_req_d_r, wait_r;

  logic           rx_active_s, rx_restart_s, rx_bit_s, rx_byte_done_s, rx_fin_s;
  logic [7:0]     rx_byte_s, pid_byte_s;
  logic           crc5_ok_s, crc16_ok_s, class_ok_s, okay_s, load_s;
  logic [15:0]    tx_crc_s;

  assign rx_active_s    = (state_r == RX_PID) || (state_r == RX_DATA);
  assign rx_restart_s   = rx_sta && ((state_r == IDLE) || rx_active_s);
  assign rx_bit_s       = rx_ena && rx_active_s && !rx_sta;
  assign rx_byte_done_s = rx_bit_s && (rx_bit_cnt_r == 3'd7);
  assign rx_fin_s       = rx_fin && rx_active_s && !rx_sta && !rx_ena;
  assign rx_byte_s      = {rx_bit, rx_sh_r[7:1]};
  assign pid_byte_s     = {~tx_pid_r, tx_pid_r};
  assign load_s         = tp_req_d_r && (state_r == TX_DATA);

`ifdef USBFS_CRC_CHECK_EN
  logic [4:0]  rx_crc5_s;
  logic [15:0] rx_crc16_s;
  logic        rx_crc_en_s;

  assign rx_crc_en_s = rx_bit_s && (state_r == RX_DATA);

  usbfs_crc #(.W(5)) u_rx_crc5 (
    .clk  (clk),
    .rst  (rst),
    .init (rx_restart_s),
    .en   (rx_crc_en_s),
    .din  (rx_bit),
    .crc  (rx_crc5_s)
  );

  usbfs_crc #(.W(16)) u_rx_crc16 (
    .clk  (clk),
    .rst  (rst),
    .init (rx_restart_s),
    .en   (rx_crc_en_s),
    .din  (rx_bit),
    .crc  (rx_crc16_s)
  );

  assign crc5_ok_s  = crc5_residual_ok(rx_crc5_s);
  assign crc16_ok_s = crc16_residual_ok(rx_crc16_s);
`else
  assign crc5_ok_s  = 1'b1;
  assign crc16_ok_s = 1'b1;
`endif

  usbfs_crc #(.W(16)) u_tx_crc16 (
    .clk  (clk),
    .rst  (rst),
    .init (state_r == RESP_WAIT),
    .en   (tx_req && (state_r == TX_DATA)),
    .din  (tx_buf_r[tx_cnt_r[2:0]]),
    .crc  (tx_crc_s)
  );

  // Packet acceptance verdict evaluated on the rx_fin cycle
  always_comb begin
    class_ok_s = 1'b0;
    case (rp_pid[1:0])
      CLS_HANDSHAKE: class_ok_s = (rx_byte_cnt_r == {BCW{1'b0}});
      CLS_TOKEN:     class_ok_s = (rx_byte_cnt_r == TWO_C) && crc5_ok_s;
      CLS_DATA:      class_ok_s = (rx_byte_cnt_r >= TWO_C) && (rx_byte_cnt_r <= MAX_LEN_C) && crc16_ok_s;
      default:       class_ok_s = 1'b0;
    endcase
    okay_s = pid_ok_r && (rx_bit_cnt_r == 3'd0) && class_ok_s;
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (rx_sta) state_s = RX_PID;
        else        state_s = IDLE;
      end
      RX_PID: begin
        if (rx_sta)              state_s = RX_PID;
        else if (rx_byte_done_s) state_s = RX_DATA;
        else if (rx_fin_s)       state_s = RESP_WAIT;
        else                     state_s = RX_PID;
      end
      RX_DATA: begin
        if (rx_sta)        state_s = RX_PID;
        else if (rx_fin_s) state_s = RESP_WAIT;
        else               state_s = RX_DATA;
      end
      RESP_WAIT: begin
        if (tp_sta)      state_s = TX_PID;
        else if (wait_r) state_s = IDLE;
        else             state_s = RESP_WAIT;
      end
      TX_PID: begin
        if (tx_req && (tx_cnt_r == 4'd7)) begin
          if (tx_pid_r[1:0] == CLS_DATA) state_s = TX_DATA;
          else                           state_s = TX_END;
        end else begin
          state_s = TX_PID;
        end
      end
      TX_DATA: begin
        if (load_s && tp_end) state_s = TX_CRC;
        else                  state_s = TX_DATA;
      end
      TX_CRC: begin
        if (tx_req && (tx_cnt_r == 4'd15)) state_s = TX_END;
        else                               state_s = TX_CRC;
      end
      TX_END: begin
        if (tx_req) state_s = IDLE;
        else        state_s = TX_END;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // RX assembly: data PIDs keep a two-byte delay line so the CRC bytes never surface
  always_ff @(posedge clk) begin
    if (rst) begin
      rp_pid        <= 4'h0;
      rp_byte       <= 8'h00;
      rp_byte_en    <= 1'b0;
      rp_fin        <= 1'b0;
      rp_okay       <= 1'b0;
      rx_sh_r       <= 8'h00;
      hold0_r       <= 8'h00;
      hold1_r       <= 8'h00;
      rx_bit_cnt_r  <= 3'd0;
      rx_byte_cnt_r <= {BCW{1'b0}};
      pid_ok_r      <= 1'b0;
    end else begin
      rp_byte_en <= 1'b0;
      rp_fin     <= 1'b0;
      rp_okay    <= 1'b0;
      if (rx_restart_s) begin
        rx_bit_cnt_r  <= 3'd0;
        rx_byte_cnt_r <= {BCW{1'b0}};
        pid_ok_r      <= 1'b0;
      end else if (rx_bit_s) begin
        rx_sh_r      <= rx_byte_s;
        rx_bit_cnt_r <= rx_bit_cnt_r + 3'd1;
        if (rx_byte_done_s) begin
          if (state_r == RX_PID) begin
            rp_pid   <= rx_byte_s[3:0];
            pid_ok_r <= (rx_byte_s[7:4] == ~rx_byte_s[3:0]);
          end else begin
            if (rx_byte_cnt_r != SAT_C) rx_byte_cnt_r <= rx_byte_cnt_r + {{(BCW-1){1'b0}}, 1'b1};
            if (rp_pid[1:0] == CLS_DATA) begin
              if (rx_byte_cnt_r >= TWO_C) begin
                rp_byte    <= hold1_r;
                rp_byte_en <= 1'b1;
              end
              hold1_r <= hold0_r;
              hold0_r <= rx_byte_s;
            end else begin
              rp_byte    <= rx_byte_s;
              rp_byte_en <= 1'b1;
            end
          end
        end
      end else if (rx_fin_s) begin
        rp_fin  <= 1'b1;
        rp_okay <= okay_s;
      end
    end
  end

  // TX sequencing: answer each tx_req one cycle later with the next bit
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_sta     <= 1'b0;
      tx_bit     <= 1'b0;
      tx_fin     <= 1'b0;
      tp_req     <= 1'b0;
      tp_req_d_r <= 1'b0;
      tx_pid_r   <= 4'h0;
      tx_cnt_r   <= 4'd0;
      tx_buf_r   <= 8'h00;
      wait_r     <= 1'b0;
    end else begin
      tx_sta     <= 1'b0;
      tx_bit     <= 1'b0;
      tx_fin     <= 1'b0;
      tp_req     <= 1'b0;
      tp_req_d_r <= tp_req;
      case (state_r)
        RESP_WAIT: begin
          wait_r <= 1'b1;
          if (tp_sta) begin
            tx_pid_r <= tp_pid;
            tx_sta   <= 1'b1;
            tx_cnt_r <= 4'd0;
          end
        end
        TX_PID: begin
          if (tx_req) begin
            tx_bit <= pid_byte_s[tx_cnt_r[2:0]];
            if (tx_cnt_r == 4'd7) begin
              tx_cnt_r <= 4'd0;
              tp_req   <= (tx_pid_r[1:0] == CLS_DATA);
            end else begin
              tx_cnt_r <= tx_cnt_r + 4'd1;
            end
          end
        end
        TX_DATA: begin
          if (tx_req) begin
            tx_bit <= tx_buf_r[tx_cnt_r[2:0]];
            if (tx_cnt_r == 4'd7) begin
              tx_cnt_r <= 4'd0;
              tp_req   <= 1'b1;
            end else begin
              tx_cnt_r <= tx_cnt_r + 4'd1;
            end
          end
          if (load_s && !tp_end) tx_buf_r <= tp_byte;
        end
        TX_CRC: begin
          if (tx_req) begin
            tx_bit   <= ~tx_crc_s[tx_cnt_r];
            tx_cnt_r <= tx_cnt_r + 4'd1;
          end
        end
        TX_END: begin
          if (tx_req) tx_fin <= 1'b1;
        end
        default: begin
          wait_r   <= 1'b0;
          tx_cnt_r <= 4'd0;
        end
      endcase
    end
  end

endmodule
